// File: rtl/bcd_timer_pkg.sv
// Shared types and BCD step helpers for the bcd_timer block.
// Digits are stored tens/units pairs; BCD ordering matches numeric ordering.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } time_t;

    localparam bcd_t       BCD_NINE = 4'd9;
    localparam bcd_t       BCD_FIVE = 4'd5;
    localparam logic [7:0] BCD_59   = 8'h59;

    // Two-digit increment; wraps {tens_lim,9} to 00, carry is left to the caller.
    function automatic logic [7:0] inc_pair(input logic [7:0] p, input bcd_t tens_lim);
        logic [7:0] r;
        if (p[3:0] >= BCD_NINE) begin
            r[3:0] = 4'd0;
            r[7:4] = (p[7:4] >= tens_lim) ? 4'd0 : p[7:4] + 4'd1;
        end else begin
            r[3:0] = p[3:0] + 4'd1;
            r[7:4] = p[7:4];
        end
        return r;
    endfunction

    function automatic logic [7:0] dec_pair(input logic [7:0] p, input bcd_t tens_lim);
        logic [7:0] r;
        if (p[3:0] == 4'd0) begin
            r[3:0] = BCD_NINE;
            r[7:4] = (p[7:4] == 4'd0) ? tens_lim : p[7:4] - 4'd1;
        end else begin
            r[3:0] = p[3:0] - 4'd1;
            r[7:4] = p[7:4];
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] h, input logic [7:0] max_hr);
        return (h >= max_hr) ? 8'h00 : inc_pair(h, BCD_NINE);
    endfunction

    // One-second step; hours stop at 00 when counting down.
    function automatic time_t step_time(input time_t t, input logic down, input logic [7:0] max_hr);
        time_t      r;
        logic [7:0] s, m, h;
        s = {t.s1, t.s0};
        m = {t.m1, t.m0};
        h = {t.h1, t.h0};
        r = t;
        if (!down) begin
            {r.s1, r.s0} = inc_pair(s, BCD_FIVE);
            if (s == BCD_59) begin
                {r.m1, r.m0} = inc_pair(m, BCD_FIVE);
                if (m == BCD_59) {r.h1, r.h0} = inc_hours(h, max_hr);
            end
        end else begin
            {r.s1, r.s0} = dec_pair(s, BCD_FIVE);
            if (s == 8'h00) begin
                {r.m1, r.m0} = dec_pair(m, BCD_FIVE);
                if (m == 8'h00 && h != 8'h00) {r.h1, r.h0} = dec_pair(h, BCD_NINE);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_timer_lap_fifo.sv
// Lap FIFO: power-of-two ring buffer with a registered head (0 when empty).
// flush empties it; a push while full only lands if a pop frees a slot that cycle.
module lap_fifo
    import bcd_timer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  push,
    input  logic  pop,
    input  time_t wdata,
    output time_t head,
    output logic  valid,
    output logic  full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    time_t         mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_inc;
    logic [AW:0]   cnt, cnt_next;
    logic          do_push, do_pop;

    assign do_pop   = pop && (cnt != '0);
    assign do_push  = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);
    assign cnt_next = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rd_inc   = rd_ptr + 1'b1;
    assign valid    = (cnt != '0);
    assign full     = (cnt == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_inc;
            cnt <= cnt_next;
            // Head follows the next oldest entry; a lone entry popped alongside a push hands over to wdata.
            if (do_pop) begin
                if (cnt == (AW+1)'(1)) head <= do_push ? wdata : '0;
                else                   head <= mem[rd_inc];
            end else if (do_push && cnt == '0) begin
                head <= wdata;
            end
        end
    end

endmodule

// File: rtl/bcd_timer.sv
// BCD stopwatch/countdown timer stepped by a 1 Hz tick, with an optional lap FIFO.
// Define BCD_TIMER_LAP_EN to build the lap FIFO; otherwise lap outputs read 0.
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int MAX_HOURS = 99,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        mode,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    input  logic        set_hr,
    input  logic        set_min,
    input  logic        lap_rd,
    output logic [23:0] count,
    output logic [23:0] lap_data,
    output logic        lap_valid,
    output logic        lap_full,
    output logic [1:0]  state,
    output logic        done
);
    localparam logic [7:0] MAX_HR_BCD = {4'(MAX_HOURS / 10), 4'(MAX_HOURS % 10)};

    state_t cur_state, state_next;
    time_t  cnt_q, count_next, stepped;
    logic   mode_q, mode_next, done_next, push;

    assign stepped = step_time(cnt_q, mode_q, MAX_HR_BCD);
    assign count   = cnt_q;
    assign state   = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= state_next;
            cnt_q     <= count_next;
            mode_q    <= mode_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = cur_state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (cur_state)
                IDLE:    if (start_stop && !(mode && cnt_q == '0)) state_next = RUN;
                RUN:     if (start_stop)                         state_next = PAUSE;
                         else if (tick && mode_q && stepped == '0) state_next = DONE;
                PAUSE:   if (start_stop) state_next = RUN;
                DONE:    if (start_stop) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        count_next = cnt_q;
        mode_next  = mode_q;
        done_next  = 1'b0;
        push       = 1'b0;
        if (clear) begin
            count_next = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (state_next == RUN) begin
                        mode_next = mode;
                    end else if (mode) begin
                        if (set_hr)  {count_next.h1, count_next.h0} = inc_hours({cnt_q.h1, cnt_q.h0}, MAX_HR_BCD);
                        if (set_min) {count_next.m1, count_next.m0} = inc_pair({cnt_q.m1, cnt_q.m0}, BCD_FIVE);
                    end
                end
                RUN: begin
                    if (!start_stop && tick) count_next = stepped;
                    done_next = (state_next == DONE);
                    // Lap samples the pre-tick register and is lost on any transition.
                    push      = lap && (state_next == RUN);
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_TIMER_LAP_EN
    time_t head;

    lap_fifo #(.DEPTH(LAP_DEPTH)) u_lap_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clear),
        .push  (push),
        .pop   (lap_rd),
        .wdata (cnt_q),
        .head  (head),
        .valid (lap_valid),
        .full  (lap_full)
    );

    assign lap_data = head;
`else
    logic unused_lap;
    assign unused_lap = ^{push, lap_rd};
    assign lap_data   = '0;
    assign lap_valid  = 1'b0;
    assign lap_full   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Scoreboard bench for bcd_timer: a 99-hour and a 2-hour instance share stimulus.
// Expectations are queued by the stimulus and checked by a negedge monitor.
module tb_bcd_timer;
`ifdef BCD_TIMER_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    localparam logic [6:0] T  = 7'b1000000;
    localparam logic [6:0] SS = 7'b0100000;
    localparam logic [6:0] L  = 7'b0010000;
    localparam logic [6:0] C  = 7'b0001000;
    localparam logic [6:0] SH = 7'b0000100;
    localparam logic [6:0] SM = 7'b0000010;
    localparam logic [6:0] RD = 7'b0000001;

    localparam int K_CNT = 0, K_ST = 1, K_DONE = 2, K_LD = 3, K_LV = 4, K_LF = 5;
    localparam int K_WCNT = 6, K_WST = 7, K_WDONE = 8, K_WLD = 9, K_WLV = 10, K_WLF = 11;

    localparam int TIMEOUT_CYCLES = 20000;

    logic        clk = 1'b0;
    logic        rst_n, tick, mode, start_stop, lap, clear, set_hr, set_min, lap_rd;
    logic [23:0] count, lap_data, w_count, w_lap_data;
    logic        lap_valid, lap_full, done, w_lap_valid, w_lap_full, w_done;
    logic [1:0]  state, w_state;

    always #5 clk = ~clk;

    bcd_timer dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .start_stop(start_stop),
        .lap(lap), .clear(clear), .set_hr(set_hr), .set_min(set_min), .lap_rd(lap_rd),
        .count(count), .lap_data(lap_data), .lap_valid(lap_valid), .lap_full(lap_full),
        .state(state), .done(done)
    );

    bcd_timer #(.MAX_HOURS(2), .LAP_DEPTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .start_stop(start_stop),
        .lap(lap), .clear(clear), .set_hr(set_hr), .set_min(set_min), .lap_rd(lap_rd),
        .count(w_count), .lap_data(w_lap_data), .lap_valid(w_lap_valid), .lap_full(w_lap_full),
        .state(w_state), .done(w_done)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [23:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [23:0] act;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [23:0] actual(input int kind);
        case (kind)
            K_CNT:   return count;
            K_ST:    return {22'd0, state};
            K_DONE:  return {23'd0, done};
            K_LD:    return lap_data;
            K_LV:    return {23'd0, lap_valid};
            K_LF:    return {23'd0, lap_full};
            K_WCNT:  return w_count;
            K_WST:   return {22'd0, w_state};
            K_WDONE: return {23'd0, w_done};
            K_WLD:   return w_lap_data;
            K_WLV:   return {23'd0, w_lap_valid};
            K_WLF:   return {23'd0, w_lap_full};
            default: return 24'hxxxxxx;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            act = actual(cur.kind);
            vectors++;
            if (act !== cur.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        miscompares++;
        $display("FAIL timeout: stimulus did not complete within %0d cycles", TIMEOUT_CYCLES);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic chk(input string nm, input int kind, input logic [23:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Drive one cycle of pulses, then leave inputs idle just after the sampling edge.
    task automatic step(input logic [6:0] v);
        {tick, start_stop, lap, clear, set_hr, set_min, lap_rd} = v;
        @(posedge clk);
        #1;
        {tick, start_stop, lap, clear, set_hr, set_min, lap_rd} = '0;
    endtask

    task automatic steps(input int n, input logic [6:0] v);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1'b0;
        {tick, start_stop, lap, clear, set_hr, set_min, lap_rd} = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (count !== 24'h0 || state !== 2'd0 || done !== 1'b0 || lap_data !== 24'h0 ||
            lap_valid !== 1'b0 || lap_full !== 1'b0 || w_count !== 24'h0 || w_state !== 2'd0 ||
            w_done !== 1'b0 || w_lap_data !== 24'h0 || w_lap_valid !== 1'b0 || w_lap_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%h state=%0d done=%b lap_data=%h lap_valid=%b lap_full=%b",
                     count, state, done, lap_data, lap_valid, lap_full);
        end
        chk("rst_count", K_CNT, 24'h0);
        chk("rst_state", K_ST, 24'd0);
        chk("rst_done", K_DONE, 24'd0);
        chk("rst_lap_data", K_LD, 24'h0);
        chk("rst_lap_valid", K_LV, 24'd0);
        chk("rst_lap_full", K_LF, 24'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stopwatch, pause, resume with a dropped tick
        mode = 1'b0;
        step(SS);            chk("sw_run", K_ST, 24'd1);
        steps(61, T);        chk("sw_61", K_CNT, 24'h000101); chk("sw_61_w", K_WCNT, 24'h000101);
        step(SS);            chk("sw_pause", K_ST, 24'd2);
        steps(5, T);         chk("sw_pause_hold", K_CNT, 24'h000101);
        step(SS | T);        chk("sw_resume", K_ST, 24'd1); chk("sw_tick_drop", K_CNT, 24'h000101);
        step(T);             chk("sw_resume_tick", K_CNT, 24'h000102);
        step(C);             chk("clr_state", K_ST, 24'd0); chk("clr_count", K_CNT, 24'h0);

        // Preload 02:59:00, run to the hour boundary
        mode = 1'b1;
        steps(2, SH);
        steps(59, SM);       chk("preload", K_CNT, 24'h025900); chk("preload_w", K_WCNT, 24'h025900);
        mode = 1'b0;
        step(SS);
        steps(59, T);        chk("pre_wrap", K_CNT, 24'h025959);
        step(T);             chk("hour_carry", K_CNT, 24'h030000);
        chk("wrap_w", K_WCNT, 24'h000000); chk("wrap_w_run", K_WST, 24'd1);
        step(C);

        // Countdown 00:02:00 to zero
        mode = 1'b1;
        steps(2, SM);        chk("cd_set", K_CNT, 24'h000200);
        step(SS);            chk("cd_run", K_ST, 24'd1);
        step(T);             chk("cd_borrow", K_CNT, 24'h000159);
        steps(118, T);       chk("cd_1s", K_CNT, 24'h000001); chk("cd_no_done", K_DONE, 24'd0);
        step(T);             chk("cd_zero", K_CNT, 24'h0); chk("cd_done", K_DONE, 24'd1);
        chk("cd_state", K_ST, 24'd3); chk("cd_done_w", K_WDONE, 24'd1);
        step(T);             chk("cd_done_pulse", K_DONE, 24'd0); chk("cd_hold", K_CNT, 24'h0);
        chk("cd_state_hold", K_ST, 24'd3);
        step(SS);            chk("done_to_idle", K_ST, 24'd0);

        // Countdown start at zero, hour/minute setting wraps
        step(SS);            chk("zero_start", K_ST, 24'd0);
        steps(99, SH);       chk("set_hr_99", K_CNT, 24'h990000); chk("set_hr_w", K_WCNT, 24'h000000);
        step(SH);            chk("set_hr_wrap", K_CNT, 24'h000000); chk("set_hr_w1", K_WCNT, 24'h010000);
        steps(60, SM);       chk("set_min_wrap", K_CNT, 24'h000000); chk("set_min_w", K_WCNT, 24'h010000);
        mode = 1'b0;
        step(SH);            chk("set_hr_sw_ign", K_CNT, 24'h000000);
        step(C);

        // Lap FIFO fill, overflow, drain
        step(SS);
        for (int i = 1; i <= 5; i++) begin
            step(T);
            step(L);
        end
        chk("lap_full", K_LF, 24'(LAP_ON)); chk("lap_valid", K_LV, 24'(LAP_ON));
        chk("lap_head", K_LD, LAP_ON ? 24'h000001 : 24'h0);
        chk("lap_full_w", K_WLF, 24'(LAP_ON));
        for (int i = 1; i <= 4; i++) begin
            step(RD);
            chk("lap_pop", K_LD, (LAP_ON && i < 4) ? 24'(i + 1) : 24'h0);
            if (i == 1) chk("lap_not_full", K_LF, 24'd0);
        end
        chk("lap_empty", K_LV, 24'd0); chk("lap_empty_w", K_WLV, 24'd0);
        step(T | L);         chk("lap_tick_cnt", K_CNT, 24'h000006);
        chk("lap_pre_tick", K_LD, LAP_ON ? 24'h000005 : 24'h0); chk("lap_pre_tick_w", K_WLD, LAP_ON ? 24'h000005 : 24'h0);
        step(C | SS | T);    chk("multi_state", K_ST, 24'd0); chk("multi_count", K_CNT, 24'h0);
        chk("multi_lv", K_LV, 24'd0); chk("multi_ld", K_LD, 24'h0);

        // Asynchronous reset in the middle of a run
        step(SS);
        steps(3, T);
        rst_n = 1'b0;
        #1;
        chk("arst_count", K_CNT, 24'h0); chk("arst_state", K_ST, 24'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(SS);
        step(T);             chk("post_rst_tick", K_CNT, 24'h000001); chk("post_rst_run", K_ST, 24'd1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised BCD stopwatch/countdown timer with a lap buffer, running entirely on the system clock. Time advances only on a 1 Hz `tick` strobe; there are no derived clocks. Its packed HH:MM:SS BCD output feeds the display RAM controller, and its button pulses come from the existing debounce/one-pulse chain. It replaces the per-digit timer chain with one block: hours wrap at a configurable bound, and several laps are queued.

## Interface
- `MAX_HOURS`, 99: highest hour value, 1..99; hours wrap from MAX_HOURS to 00.
- `LAP_DEPTH`, 4: lap FIFO entries, power of two, 2..16.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle 1 Hz strobe.
- `mode` in 1: 0 = stopwatch (up), 1 = countdown (down). Sampled only in IDLE.
- `start_stop` in 1: one-cycle pulse.
- `lap` in 1: one-cycle pulse.
- `clear` in 1: one-cycle pulse.
- `set_hr` in 1: one-cycle pulse, IDLE + countdown only.
- `set_min` in 1: one-cycle pulse, IDLE + countdown only.
- `lap_rd` in 1: one-cycle pulse, pops the FIFO head.
- `count` out 24: {h1,h0,m1,m0,s1,s0}, BCD.
- `lap_data` out 24: FIFO head, same format.
- `lap_valid` out 1: FIFO non-empty.
- `lap_full` out 1: FIFO full.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `done` out 1: one-cycle pulse when a countdown reaches zero.

## Operation
- Reset values:
  - `count`, `lap_data` = 0; `state` = IDLE; `lap_valid`, `lap_full`, `done` = 0.
  - FIFO is empty; latched mode = 0.
- **IDLE**
  - `start_stop` → RUN, latching `mode`.
  - A countdown with `count`==0 ignores `start_stop` and stays in IDLE.
  - `set_hr`: hours +1, MAX_HOURS → 00.
  - `set_min`: minutes +1, 59 → 00, no carry into hours.
- **RUN**
  - Each `tick` steps `count` by one second in the latched direction.
  - `start_stop` → PAUSE.
  - `lap` pushes the current `count`.
- **PAUSE**
  - `count` holds.
  - `start_stop` → RUN.
- **DONE**
  - Entered when a countdown step produces 00:00:00.
  - `count` holds at zero.
  - `start_stop` or `clear` → IDLE.
- **clear** (any state): → IDLE, `count` = 0, FIFO flushed.
- Up-count carries: s0 9→0 carries into s1; s1 5→0 carries into minutes; minutes follow the same pattern; 59:59 carries into hours.
- Stopwatch wrap: at MAX_HOURS:59:59 the next tick gives 00:00:00 and the block stays in RUN.
- Down-count borrows mirror the up-count carries: s0 0→9, s1 0→5, and so on. Hours borrow from the current value and never go below 00.
- Every digit is always a legal BCD value. Seconds and minutes tens digits never exceed 5.
- Simultaneous-event priority: `clear` > `start_stop` > `tick` > `lap`.
  - A `tick` in the same cycle as any state transition is dropped.
  - A `lap` in the same cycle as a transition is dropped.
  - A `lap` in the same cycle as a `tick` captures the pre-tick value.
- Lap FIFO:
  - A push when full is discarded; the stored contents are unchanged.
  - `lap_rd` when empty is ignored.
  - A push and a pop in the same cycle both take effect, and occupancy is unchanged.
- `lap`, `set_hr` and `set_min` are ignored in any state where they are not listed above.

## Timing
- All outputs are registered.
- `count` reflects a `tick` one cycle after the strobe.
- `state` changes one cycle after the causing pulse.
- `done` is high for exactly one cycle, aligned with `count` first reading 0 and `state`=DONE.
- `lap_data` and `lap_valid` update the cycle after a push or pop. `lap_data` is the oldest entry, and is 0 when the FIFO is empty.
- Asynchronous reset mid-run clears everything immediately. The first `tick` after release is treated normally.

## Configuration
- `BCD_TIMER_LAP_EN` defined: the lap FIFO is built, as described above.
- Not defined:
  - No FIFO storage is synthesised.
  - `lap` and `lap_rd` are ignored.
  - `lap_data` = 0, `lap_valid` = 0, `lap_full` = 0.
  - All other behaviour is identical.

## Structure
- `bcd_timer_pkg` contains:
  - the state enum;
  - the 4-bit BCD digit typedef;
  - a packed 24-bit time struct;
  - constants for 59 and 9.
- Sub-module `lap_fifo`:
  - parametrised by `LAP_DEPTH`, 24-bit data;
  - registered head output, full/empty flags;
  - instantiated only under `BCD_TIMER_LAP_EN`.
- Step logic (increment/decrement with carry and borrow) is a function in the package.

## Test plan
- Stopwatch: start, then 61 ticks → `count`=00:01:01. `start_stop` → PAUSE. 5 more ticks → still 00:01:01.
- Wrap, with MAX_HOURS=2: preload by ticking to 02:59:59, then 1 tick → 00:00:00, `state`=RUN.
- Countdown: IDLE, mode=1. `set_min`×2 → 00:02:00. Start, then 120 ticks → `count`=0, `done` high for one cycle, `state`=DONE. Extra ticks → no change.
- Countdown start at zero: `start_stop` → `state` stays IDLE. `set_hr` with hours at 99 → 00.
- Laps (LAP_DEPTH=4):
  - 5 laps at 1 s spacing → `lap_full`=1, entries 1..4 s, fifth dropped.
  - 4 `lap_rd` → values 00:00:01..00:00:04 in order, then `lap_valid`=0.
- Simultaneous events: `clear`+`start_stop`+`tick` in one cycle during RUN → IDLE, `count`=0, FIFO empty. `lap`+`tick` → captured value is the pre-tick value.
